// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 constants: post-modify codes, register select codes and the
// Y-space AAU sequencing states.
package jtdsp16_pkg;

    localparam logic [2:0] PM_NONE = 3'd0;
    localparam logic [2:0] PM_INC  = 3'd1;
    localparam logic [2:0] PM_DEC  = 3'd2;
    localparam logic [2:0] PM_J    = 3'd3;
    localparam logic [2:0] PM_K    = 3'd4;

    localparam logic [2:0] SEL_R0  = 3'd0;
    localparam logic [2:0] SEL_R1  = 3'd1;
    localparam logic [2:0] SEL_R2  = 3'd2;
    localparam logic [2:0] SEL_R3  = 3'd3;
    localparam logic [2:0] SEL_RB  = 3'd4;
    localparam logic [2:0] SEL_RE  = 3'd5;
    localparam logic [2:0] SEL_J   = 3'd6;
    localparam logic [2:0] SEL_K   = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_CMPD_WR
    } yaau_state_t;

endpackage

// File: rtl/jtdsp16_yaau_mod.sv
// Combinational next-pointer calculator with rb/re circular wrap on +1.
// Shared by the Y-space and X-space address units.
module jtdsp16_yaau_mod
    import jtdsp16_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic [AW-1:0] r,
    input  logic [2:0]    post_mod,
    input  logic [AW-1:0] j,
    input  logic [AW-1:0] k,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] re,
    output logic [AW-1:0] nxt_r
);

    localparam logic [AW-1:0] ONE = AW'(1);

    // NOTE: nxt_r gets a default before the case so no latch is inferred.
    always_comb begin
        nxt_r = r;
        case (post_mod)
            // Only +1 honours the circular buffer; re == 0 disables it.
            PM_INC:  nxt_r = (re != '0 && r == re) ? rb : r + ONE;
            PM_DEC:  nxt_r = r - ONE;
            PM_J:    nxt_r = r + j;
            PM_K:    nxt_r = r + k;
            default: nxt_r = r;
        endcase
    end

endmodule

// File: rtl/jtdsp16_yaau.sv
// DSP16 Y-space address arithmetic unit: pointer file, post-modification
// and the two-cycle compound read-then-write sequencer.
module jtdsp16_yaau
    import jtdsp16_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          acc_en,
    input  logic          acc_wr,
    input  logic          cmpd,
    input  logic [1:0]    ptr_sel,
    input  logic [2:0]    post_mod,
    input  logic [15:0]   wr_data,
    input  logic          ld_en,
    input  logic [2:0]    ld_sel,
    input  logic [15:0]   ld_data,
    input  logic [2:0]    rd_sel,
    output logic [15:0]   rd_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [15:0]   ram_din,
    output logic          busy
);

    logic [AW-1:0] r [4];
    logic [AW-1:0] rb, re;
    logic [15:0]   j, k;

    yaau_state_t   st;
    logic [AW-1:0] lat_addr;
    logic [15:0]   lat_data;
    logic [1:0]    lat_ptr;
    logic [2:0]    lat_pm;

    logic          in_wr, accept, mod_en;
    logic [1:0]    mod_ptr;
    logic [AW-1:0] mod_r, nxt_r;
    logic [2:0]    mod_pm;

    assign in_wr   = (st == ST_CMPD_WR);
    assign accept  = (st == ST_IDLE) && acc_en;
    // A compound access post-modifies only in its write phase.
    assign mod_en  = (accept && !cmpd) || in_wr;
    assign mod_ptr = in_wr ? lat_ptr  : ptr_sel;
    assign mod_r   = in_wr ? lat_addr : r[ptr_sel];
    assign mod_pm  = in_wr ? lat_pm   : post_mod;

    jtdsp16_yaau_mod #(.AW(AW)) u_mod (
        .r        (mod_r),
        .post_mod (mod_pm),
        .j        (j[AW-1:0]),
        .k        (k[AW-1:0]),
        .rb       (rb),
        .re       (re),
        .nxt_r    (nxt_r)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            ram_addr <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_din  <= '0;
            busy     <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_ptr  <= '0;
            lat_pm   <= PM_NONE;
        end else if (cen) begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (acc_en) begin
                        ram_addr <= r[ptr_sel];
                        ram_cs   <= 1'b1;
                        if (cmpd) begin
                            lat_addr <= r[ptr_sel];
                            lat_data <= wr_data;
                            lat_ptr  <= ptr_sel;
                            lat_pm   <= post_mod;
                            busy     <= 1'b1;
                            st       <= ST_CMPD_WR;
                        end else begin
                            ram_we  <= acc_wr;
                            ram_din <= wr_data;
                        end
                    end
                end
                ST_CMPD_WR: begin
                    ram_addr <= lat_addr;
                    ram_cs   <= 1'b1;
                    ram_we   <= 1'b1;
                    ram_din  <= lat_data;
                    busy     <= 1'b0;
                    st       <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the small pointer file is flop-based, so it takes the async
    // reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r[i] <= '0;
            rb <= '0;
            re <= '0;
            j  <= '0;
            k  <= '0;
        end else if (cen) begin
            for (int i = 0; i < 4; i++) begin
                // An explicit load beats the post-modify of the same pointer.
                if (ld_en && !ld_sel[2] && ld_sel[1:0] == 2'(i))
                    r[i] <= ld_data[AW-1:0];
                else if (mod_en && mod_ptr == 2'(i))
                    r[i] <= nxt_r;
            end
            if (ld_en) begin
                case (ld_sel)
                    SEL_RB:  rb <= ld_data[AW-1:0];
                    SEL_RE:  re <= ld_data[AW-1:0];
                    SEL_J:   j  <= ld_data;
                    SEL_K:   k  <= ld_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_R0:  rd_data = 16'(r[0]);
            SEL_R1:  rd_data = 16'(r[1]);
            SEL_R2:  rd_data = 16'(r[2]);
            SEL_R3:  rd_data = 16'(r[3]);
            SEL_RB:  rd_data = 16'(rb);
            SEL_RE:  rd_data = 16'(re);
            SEL_J:   rd_data = j;
            SEL_K:   rd_data = k;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Directed bench for jtdsp16_yaau: hand-computed vectors covering post-modify,
// circular wrap, loads, compound sequencing, reset and clock-enable freeze.
module tb_jtdsp16_yaau;
    import jtdsp16_pkg::*;

    localparam int AW = 11;

    logic          rst, clk, cen;
    logic          acc_en, acc_wr, cmpd;
    logic [1:0]    ptr_sel;
    logic [2:0]    post_mod;
    logic [15:0]   wr_data;
    logic          ld_en;
    logic [2:0]    ld_sel;
    logic [15:0]   ld_data;
    logic [2:0]    rd_sel;
    logic [15:0]   rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_cs, ram_we;
    logic [15:0]   ram_din;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    jtdsp16_yaau #(.AW(AW)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .acc_en   (acc_en),
        .acc_wr   (acc_wr),
        .cmpd     (cmpd),
        .ptr_sel  (ptr_sel),
        .post_mod (post_mod),
        .wr_data  (wr_data),
        .ld_en    (ld_en),
        .ld_sel   (ld_sel),
        .ld_data  (ld_data),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .ram_addr (ram_addr),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time at posedge+1 for sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        rd_sel = sel;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic load(input logic [2:0] sel, input logic [15:0] data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic access(input logic [1:0] ptr, input logic [2:0] pm,
                          input logic wr, input logic cp, input logic [15:0] data);
        acc_en   = 1'b1;
        ptr_sel  = ptr;
        post_mod = pm;
        acc_wr   = wr;
        cmpd     = cp;
        wr_data  = data;
        step();
        acc_en   = 1'b0;
        cmpd     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1;
        acc_en = 1'b0; acc_wr = 1'b0; cmpd = 1'b0;
        ptr_sel = '0; post_mod = PM_NONE; wr_data = '0;
        ld_en = 1'b0; ld_sel = '0; ld_data = '0; rd_sel = SEL_R0;

        repeat (2) step();
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_cs",   32'(ram_cs),   0);
        check("rst_we",   32'(ram_we),   0);
        check("rst_din",  32'(ram_din),  0);
        check("rst_busy", 32'(busy),     0);
        check_reg("rst_r0", SEL_R0, 16'h0000);
        rst = 1'b0;
        step();

        // Simple access with +1
        load(SEL_R0, 16'h0005);
        access(2'd0, PM_INC, 1'b0, 1'b0, 16'h0000);
        check("s_addr", 32'(ram_addr), 32'h005);
        check("s_cs",   32'(ram_cs),   1);
        check("s_we",   32'(ram_we),   0);
        check_reg("s_r0", SEL_R0, 16'h0006);
        step();
        check("idle_cs",   32'(ram_cs),   0);
        check("idle_hold", 32'(ram_addr), 32'h005);

        // Circular wrap on +1, then -1 does not wrap
        load(SEL_RB, 16'h0010);
        load(SEL_RE, 16'h0013);
        load(SEL_R1, 16'h0013);
        access(2'd1, PM_INC, 1'b0, 1'b0, 16'h0000);
        check("cb_addr", 32'(ram_addr), 32'h013);
        check_reg("cb_r1", SEL_R1, 16'h0010);
        access(2'd1, PM_DEC, 1'b1, 1'b0, 16'h1234);
        check("dec_addr", 32'(ram_addr), 32'h010);
        check("dec_we",   32'(ram_we),   1);
        check("dec_din",  32'(ram_din),  32'h1234);
        check_reg("dec_r1", SEL_R1, 16'h000F);
        access(2'd1, PM_INC, 1'b0, 1'b0, 16'h0000);
        check_reg("inc_r1", SEL_R1, 16'h0010);

        // +j with negative j, then +k wrapping past 2^AW
        load(SEL_J, 16'hFFFE);
        load(SEL_R2, 16'h0000);
        access(2'd2, PM_J, 1'b0, 1'b0, 16'h0000);
        check("j_addr", 32'(ram_addr), 32'h000);
        check_reg("j_r2", SEL_R2, 16'h07FE);
        load(SEL_K, 16'h0003);
        access(2'd2, PM_K, 1'b0, 1'b0, 16'h0000);
        check("k_addr", 32'(ram_addr), 32'h7FE);
        check_reg("k_r2", SEL_R2, 16'h0001);
        check_reg("k_rd", SEL_K, 16'h0003);

        // Compound access on r3, acc_en held during the write phase
        load(SEL_R3, 16'h0020);
        access(2'd3, PM_INC, 1'b1, 1'b1, 16'hBEEF);
        check("c1_cs",   32'(ram_cs),   1);
        check("c1_we",   32'(ram_we),   0);
        check("c1_addr", 32'(ram_addr), 32'h020);
        check("c1_busy", 32'(busy),     1);
        acc_en = 1'b1; ptr_sel = 2'd0; post_mod = PM_INC; acc_wr = 1'b1; wr_data = 16'h5555;
        step();
        acc_en = 1'b0;
        check("c2_we",   32'(ram_we),   1);
        check("c2_din",  32'(ram_din),  32'hBEEF);
        check("c2_addr", 32'(ram_addr), 32'h020);
        check("c2_busy", 32'(busy),     0);
        check_reg("c2_r3", SEL_R3, 16'h0021);
        check_reg("c2_r0", SEL_R0, 16'h0006);
        step();
        check("c3_cs", 32'(ram_cs), 0);

        // Load beats post-modify of the same pointer
        ld_en = 1'b1; ld_sel = SEL_R0; ld_data = 16'h0040;
        access(2'd0, PM_INC, 1'b0, 1'b0, 16'h0000);
        ld_en = 1'b0;
        check("ldw_addr", 32'(ram_addr), 32'h006);
        check_reg("ldw_r0", SEL_R0, 16'h0040);

        // -1 from zero wraps modulo 2^AW
        load(SEL_R0, 16'h0000);
        access(2'd0, PM_DEC, 1'b0, 1'b0, 16'h0000);
        check_reg("dec0_r0", SEL_R0, 16'h07FF);

        // Reset pulsed between compound read and write phases
        access(2'd3, PM_INC, 1'b0, 1'b1, 16'hDEAD);
        check("rc_busy", 32'(busy), 1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("rc_busy0", 32'(busy),   0);
        check("rc_we0",   32'(ram_we), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rc_no_wr", 32'(ram_we), 0);
        end
        check_reg("rc_r3", SEL_R3, 16'h0000);

        // cen=0 freezes a compound sequence mid-way
        load(SEL_R1, 16'h0030);
        access(2'd1, PM_DEC, 1'b0, 1'b1, 16'hCAFE);
        check("ce_busy", 32'(busy), 1);
        cen = 1'b0;
        ld_en = 1'b1; ld_sel = SEL_R1; ld_data = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ce_hold_busy", 32'(busy),     1);
            check("ce_hold_cs",   32'(ram_cs),   1);
            check("ce_hold_we",   32'(ram_we),   0);
            check("ce_hold_addr", 32'(ram_addr), 32'h030);
        end
        ld_en = 1'b0;
        check_reg("ce_r1", SEL_R1, 16'h0030);
        cen = 1'b1;
        step();
        check("ce_we",   32'(ram_we),   1);
        check("ce_din",  32'(ram_din),  32'hCAFE);
        check("ce_addr", 32'(ram_addr), 32'h030);
        check("ce_busy0", 32'(busy),    0);
        check_reg("ce_r1m", SEL_R1, 16'h002F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
